mac_dot_seq: RTL and testbench

//  Initiator/sequencer for mac_pipe: accepts an (a,b) operand stream with valid/ready
//  and a last marker, and issues one MAC op per accepted pair. It supplies acc_in from
//  MAC_LAT rotating partial-sum lanes, with forwarding, so that back-to-back issue

---
 rtl/mac_dot_seq_if.sv | 40 ++++
 rtl/mac_dot_seq.sv | 114 +++++++++++
 tb/tb_mac_dot_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_seq_if.sv
// Operand, mac_pipe and result signals of mac_dot_seq bundled in one interface.
// The sequencer connects through the slave modport; its environment uses master.
interface mac_dot_seq_if #(
   parameter int A_W   = 8,
   parameter int B_W   = 8,
   parameter int ACC_W = 24,
   parameter int CNT_W = 16
);
   // Handshakes: a transfer happens on a rising clk edge where valid && ready;
   // the sender holds payload stable while valid is high and ready is low.
   logic             s_valid;
   logic             s_ready;
   logic [A_W-1:0]   s_a;
   logic [B_W-1:0]   s_b;
   logic             s_last;
   logic             mac_in_valid;
   logic [A_W-1:0]   mac_a;
   logic [B_W-1:0]   mac_b;
   logic [ACC_W-1:0] mac_acc_in;
   logic             mac_out_valid;
   logic [ACC_W-1:0] mac_y;
   logic             res_valid;
   logic             res_ready;
   logic [ACC_W-1:0] res_data;
   logic [CNT_W-1:0] res_count;
   logic             err_unexp;
   logic [1:0]       dbg_state;

   modport slave (
      input  s_valid, s_a, s_b, s_last, mac_out_valid, mac_y, res_ready,
      output s_ready, mac_in_valid, mac_a, mac_b, mac_acc_in,
             res_valid, res_data, res_count, err_unexp, dbg_state
   );

   modport master (
      output s_valid, s_a, s_b, s_last, mac_out_valid, mac_y, res_ready,
      input  s_ready, mac_in_valid, mac_a, mac_b, mac_acc_in,
             res_valid, res_data, res_count, err_unexp, dbg_state
   );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer for mac_pipe: rotates MAC_LAT partial-sum lanes so
// back-to-back operand pairs never stall, then drains, reduces and reports.
module mac_dot_seq #(
   parameter int A_W     = 8,
   parameter int B_W     = 8,
   parameter int ACC_W   = 24,
   parameter int MAC_LAT = 3,
   parameter int CNT_W   = 16
) (
   input logic         clk,
   input logic         rst,
   mac_dot_seq_if.slave bus
);
   localparam int IDX_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam int INF_W = $clog2(MAC_LAT + 2);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAC_LAT - 1);

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DRAIN  = 2'd1,
      REDUCE = 2'd2,
      OUT    = 2'd3
   } state_t;

   state_t           state, state_next;
   logic [ACC_W-1:0] lane [MAC_LAT];
   logic [IDX_W-1:0] tag_line [MAC_LAT];
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] tag_out;
   logic [CNT_W-1:0] count;
   logic [INF_W-1:0] inflight, inflight_next;
   logic [ACC_W-1:0] lane_sum;
   logic [ACC_W-1:0] res_data_q;
   logic [CNT_W-1:0] res_count_q;
   logic             err_q;
   logic             issue, ret;

   assign issue   = bus.s_valid && bus.s_ready;
   assign tag_out = tag_line[MAC_LAT-1];
   // A return with nothing in flight is stray: it is flagged, never written.
   assign ret     = bus.mac_out_valid && (inflight != '0);
   assign inflight_next = inflight + INF_W'(issue) - INF_W'(ret);

   assign bus.mac_in_valid = issue;
   assign bus.mac_a        = bus.s_a;
   assign bus.mac_b        = bus.s_b;
   // The lane being issued may be returning this very cycle; take the fresh sum.
   assign bus.mac_acc_in   = (ret && tag_out == idx) ? bus.mac_y : lane[idx];
   assign bus.res_data     = res_data_q;
   assign bus.res_count    = res_count_q;
   assign bus.err_unexp    = err_q;
   assign bus.dbg_state    = state;

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < MAC_LAT; i++) lane_sum = lane_sum + lane[i];
   end

   always_comb begin
      state_next    = state;
      bus.s_ready   = 1'b0;
      bus.res_valid = 1'b0;
      case (state)
         ACCUM: begin
            bus.s_ready = 1'b1;
            if (issue && bus.s_last) state_next = DRAIN;
         end
         DRAIN:  if (inflight_next == '0) state_next = REDUCE;
         REDUCE: state_next = OUT;
         OUT: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready) state_next = ACCUM;
         end
         default: state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ACCUM;
         idx         <= '0;
         count       <= '0;
         inflight    <= '0;
         res_data_q  <= '0;
         res_count_q <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < MAC_LAT; i++) begin
            lane[i]     <= '0;
            tag_line[i] <= '0;
         end
      end else begin
         state    <= state_next;
         inflight <= inflight_next;
         // Shifts every cycle so a tag lines up with its result exactly MAC_LAT later.
         tag_line[0] <= idx;
         for (int i = 1; i < MAC_LAT; i++) tag_line[i] <= tag_line[i-1];
         if (ret) lane[tag_out] <= bus.mac_y;
         if (bus.mac_out_valid && inflight == '0) err_q <= 1'b1;
         if (issue) begin
            idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            count <= count + 1'b1;
         end
         if (state == REDUCE) begin
            res_data_q  <= lane_sum;
            res_count_q <= count;
         end
         if (state == OUT && bus.res_ready) begin
            idx   <= '0;
            count <= '0;
            for (int i = 0; i < MAC_LAT; i++) lane[i] <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural unsigned mac_pipe and a
// scoreboard of expected dot products.
module tb_mac_dot_seq;
   localparam int A_W     = 8;
   localparam int B_W     = 8;
   localparam int ACC_W   = 24;
   localparam int MAC_LAT = 3;
   localparam int CNT_W   = 16;

   logic clk;
   logic rst;
   logic inject;
   int   cyc;
   int   last_hs;
   int   errors;
   int   checks;

   logic [ACC_W-1:0] exp_q[$];
   logic [CNT_W-1:0] exp_cnt_q[$];

   mac_dot_seq_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   mac_dot_seq #(
      .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always_ff @(posedge clk) cyc <= cyc + 1;

   // mac_pipe model: y = acc_in + a*b, MAC_LAT cycles later
   logic [MAC_LAT-1:0] pv;
   logic [ACC_W-1:0]   py [MAC_LAT];
   always_ff @(posedge clk) begin
      if (rst) begin
         pv <= '0;
      end else begin
         pv <= {pv[MAC_LAT-2:0], bus.mac_in_valid};
      end
      py[0] <= bus.mac_acc_in + ACC_W'(bus.mac_a) * ACC_W'(bus.mac_b);
      for (int i = 1; i < MAC_LAT; i++) py[i] <= py[i-1];
   end
   assign bus.mac_out_valid = pv[MAC_LAT-1] | inject;
   assign bus.mac_y         = py[MAC_LAT-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // driver: called at a negedge, returns at the negedge after the handshake
   task automatic send_pair(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input bit last);
      int guard;
      guard = 0;
      bus.s_valid = 1'b1;
      bus.s_a     = a;
      bus.s_b     = b;
      bus.s_last  = last;
      while (!bus.s_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("s_ready_timeout", 32'(bus.s_ready), 32'd1);
      last_hs = cyc;
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic send_vec(input int n, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                           input bit gap);
      for (int i = 0; i < n; i++) begin
         send_pair(a, b, i == n - 1);
         if (gap) @(negedge clk);
      end
   endtask

   // scoreboard: pop and compare when the result appears
   task automatic wait_result(input int hold, input bit chk_lat);
      int guard;
      logic [ACC_W-1:0] ed;
      logic [CNT_W-1:0] ec;
      guard = 0;
      while (!bus.res_valid && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      check("res_valid_timeout", 32'(bus.res_valid), 32'd1);
      if (chk_lat) check("latency", 32'(cyc - last_hs), 32'(MAC_LAT + 2));
      ed = exp_q.pop_front();
      ec = exp_cnt_q.pop_front();
      check("res_data", 32'(bus.res_data), 32'(ed));
      check("res_count", 32'(bus.res_count), 32'(ec));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.res_valid), 32'd1);
         check("hold_data", 32'(bus.res_data), 32'(ed));
         check("hold_s_ready", 32'(bus.s_ready), 32'd0);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check("post_s_ready", 32'(bus.s_ready), 32'd1);
      check("post_res_valid", 32'(bus.res_valid), 32'd0);
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      cyc           = 0;
      last_hs       = 0;
      inject        = 1'b0;
      rst           = 1'b1;
      bus.s_valid   = 1'b0;
      bus.s_a       = '0;
      bus.s_b       = '0;
      bus.s_last    = 1'b0;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_s_ready", 32'(bus.s_ready), 32'd1);
      check("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_mac_in_valid", 32'(bus.mac_in_valid), 32'd0);
      check("rst_res_data", 32'(bus.res_data), 32'd0);
      check("rst_res_count", 32'(bus.res_count), 32'd0);
      check("rst_err", 32'(bus.err_unexp), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'd0);

      // [1,2,3,4].[5,6,7,8]
      exp_q.push_back(24'd70); exp_cnt_q.push_back(16'd4);
      send_pair(8'd1, 8'd5, 1'b0);
      send_pair(8'd2, 8'd6, 1'b0);
      send_pair(8'd3, 8'd7, 1'b0);
      send_pair(8'd4, 8'd8, 1'b1);
      wait_result(0, 1'b1);

      // single pair
      exp_q.push_back(24'd40000); exp_cnt_q.push_back(16'd1);
      send_pair(8'd200, 8'd200, 1'b1);
      wait_result(0, 1'b1);

      // lane reuse with forwarding, then with gaps
      exp_q.push_back(24'd7); exp_cnt_q.push_back(16'd7);
      send_vec(7, 8'd1, 8'd1, 1'b0);
      wait_result(0, 1'b1);
      exp_q.push_back(24'd7); exp_cnt_q.push_back(16'd7);
      send_vec(7, 8'd1, 8'd1, 1'b1);
      wait_result(0, 1'b0);

      // back-pressure on the result
      exp_q.push_back(24'd59); exp_cnt_q.push_back(16'd2);
      send_pair(8'd4, 8'd6, 1'b0);
      send_pair(8'd5, 8'd7, 1'b1);
      wait_result(10, 1'b1);
      exp_q.push_back(24'd6); exp_cnt_q.push_back(16'd1);
      send_pair(8'd2, 8'd3, 1'b1);
      wait_result(0, 1'b1);

      // reset mid-vector
      send_pair(8'd9, 8'd9, 1'b0);
      send_pair(8'd7, 8'd7, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_s_ready", 32'(bus.s_ready), 32'd1);
      check("midrst_state", 32'(bus.dbg_state), 32'd0);
      exp_q.push_back(24'd9); exp_cnt_q.push_back(16'd1);
      send_pair(8'd3, 8'd3, 1'b1);
      wait_result(0, 1'b1);
      check("midrst_err", 32'(bus.err_unexp), 32'd0);

      // long vector with accumulator wrap
      exp_q.push_back(24'd2730284); exp_cnt_q.push_back(16'd300);
      send_vec(300, 8'hFF, 8'hFF, 1'b0);
      wait_result(0, 1'b1);

      // stray mac_out_valid while idle
      inject = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      check("err_set", 32'(bus.err_unexp), 32'd1);
      exp_q.push_back(24'd12); exp_cnt_q.push_back(16'd1);
      send_pair(8'd3, 8'd4, 1'b1);
      wait_result(0, 1'b1);
      check("err_sticky", 32'(bus.err_unexp), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("err_cleared", 32'(bus.err_unexp), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
